// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. It holds the program counter and
//                the IF/ID pipeline register, and drives a word address to a
//                combinational-read instruction memory. The stage supports
//                decode stalls, IF/ID flushes, branch redirects, a fault tag
//                for fetches beyond the memory, and a sticky misalignment
//                flag for redirect targets.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC    byte address loaded into the PC on reset
//    IMEM_AW     instruction-memory word-address width (2**IMEM_AW words)
//  Ports
//    clk         system clock, rising-edge active
//    rst         asynchronous active-high reset
//    stall       hold the PC and IF/ID
//    flush       replace the IF/ID contents with a bubble
//    br_taken    one-cycle redirect request
//    br_target   redirect byte address
//    imem_addr   word address to instruction memory = {2'b00, pc[31:2]}
//    imem_data   instruction word for imem_addr (combinational return)
//    pc          current fetch byte address
//    id_pc       byte address of the instruction in IF/ID
//    id_pc4      id_pc + 4, registered together with id_pc
//    id_inst     instruction in IF/ID (32'h0 for a bubble or faulted fetch)
//    id_valid    IF/ID holds a real instruction
//    id_fault    IF/ID fetch address lay outside instruction memory
//    misalign    sticky: a redirect target had nonzero low bits
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_fault,
    output logic        misalign
);

    // Any address bit at or above this position lies outside instruction
    // memory (word address bits plus the two byte-offset bits).
    localparam int          c_FAULT_LSB = IMEM_AW + 2;
    localparam logic [31:0] c_NOP       = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP   = 32'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_fault;
    logic        r_misalign;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [31:0] w_pc_plus4;    // wraps modulo 2**32 with no flag
    logic        w_fetch_fault;
    logic        w_tgt_misal;
    logic [31:0] w_tgt_aligned;

    assign w_pc_plus4    = r_pc + c_PC_STEP;
    assign w_fetch_fault = |(r_pc >> c_FAULT_LSB);
    assign w_tgt_misal   = |br_target[1:0];
    assign w_tgt_aligned = {br_target[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [31:0] w_pc_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_pc4_nxt;
    logic [31:0] w_id_inst_nxt;
    logic        w_id_valid_nxt;
    logic        w_id_fault_nxt;
    logic        w_misalign_nxt;

    always_comb begin
        // Default: every register holds.
        w_pc_nxt       = r_pc;
        w_id_pc_nxt    = r_id_pc;
        w_id_pc4_nxt   = r_id_pc4;
        w_id_inst_nxt  = r_id_inst;
        w_id_valid_nxt = r_id_valid;
        w_id_fault_nxt = r_id_fault;
        w_misalign_nxt = r_misalign;

        if (br_taken) begin
            // A redirect overrides both stall and flush. The IF/ID entry
            // becomes a bubble; id_pc/id_pc4 keep their old contents.
            w_pc_nxt       = w_tgt_aligned;
            w_id_inst_nxt  = c_NOP;
            w_id_valid_nxt = 1'b0;
            w_id_fault_nxt = 1'b0;
            w_misalign_nxt = r_misalign | w_tgt_misal;
        end else begin
            if (!stall) begin
                w_pc_nxt = w_pc_plus4;
            end

            if (flush) begin
                // Flush inserts a bubble even while stalled.
                w_id_inst_nxt  = c_NOP;
                w_id_valid_nxt = 1'b0;
                w_id_fault_nxt = 1'b0;
            end else if (!stall) begin
                // Normal capture. A faulted fetch carries its address but
                // no instruction and is not marked valid.
                w_id_pc_nxt    = r_pc;
                w_id_pc4_nxt   = w_pc_plus4;
                w_id_inst_nxt  = w_fetch_fault ? c_NOP : imem_data;
                w_id_valid_nxt = ~w_fetch_fault;
                w_id_fault_nxt = w_fetch_fault;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_id_pc    <= 32'h0;
            r_id_pc4   <= 32'h0;
            r_id_inst  <= c_NOP;
            r_id_valid <= 1'b0;
            r_id_fault <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_pc4   <= w_id_pc4_nxt;
            r_id_inst  <= w_id_inst_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_id_fault <= w_id_fault_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: straight from registers, no added latency
    // ------------------------------------------------------------------
    assign pc        = r_pc;
    assign imem_addr = {2'b00, r_pc[31:2]};
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc4;
    assign id_inst   = r_id_inst;
    assign id_valid  = r_id_valid;
    assign id_fault  = r_id_fault;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 SHALL have parameter IMEM_AW, default 6, the instruction-memory word-address width (64 words).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-006 SHALL have port flush  input  1  squash the IF/ID contents (insert bubble).
REQ-007 SHALL have port br_taken  input  1  redirect request, valid for one cycle.
REQ-008 SHALL have port br_target  input  32  redirect byte address.
REQ-009 SHALL have port imem_addr  output  32  word address to instruction memory, = {2'b00, pc[31:2]}.
REQ-010 SHALL have port imem_data  input  32  instruction word returned for imem_addr, valid before the next rising edge.
REQ-011 SHALL have port pc  output  32  current fetch byte address.
REQ-012 SHALL have port id_pc  output  32  byte address of the instruction in IF/ID.
REQ-013 SHALL have port id_pc4  output  32  id_pc + 4.
REQ-014 SHALL have port id_inst  output  32  instruction held in IF/ID.
REQ-015 SHALL have port id_valid  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port id_fault  output  1  IF/ID instruction was fetched outside instruction memory.
REQ-017 SHALL have port misalign  output  1  sticky flag, set when a redirect target has br_target[1:0] != 0.

Function
REQ-018 SHALL update state only on posedge clk; priority per edge: br_taken > stall > normal advance.
REQ-019 Normal advance SHALL load pc <= pc + 4 and IF/ID <= {pc, pc+4, imem_data, valid=1, fault}.
REQ-020 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-021 fault SHALL be 1 when pc[31:IMEM_AW+2] != 0; then id_inst SHALL be 32'h0 and id_valid 0.
REQ-022 stall (br_taken=0) SHALL hold pc and all IF/ID fields unchanged.
REQ-023 br_taken SHALL load pc <= {br_target[31:2], 2'b00} and clear IF/ID (id_valid=0, id_inst=0, id_fault=0), regardless of stall.
REQ-024 br_taken with br_target[1:0] != 0 SHALL set misalign; misalign SHALL clear only on rst.
REQ-025 flush without br_taken SHALL clear IF/ID as in REQ-023; pc SHALL advance per REQ-019 unless stall=1, in which case pc holds.
REQ-026 flush and stall together SHALL clear IF/ID and hold pc (bubble wins over hold in IF/ID).
REQ-027 imem_addr and pc SHALL be combinational from the PC register with zero added latency; instruction capture latency from pc to id_inst SHALL be exactly one rising edge.
REQ-028 id_pc4 SHALL be registered with id_pc, not recomputed combinationally.
REQ-029 Bubble encoding SHALL be id_inst=32'h0 (architectural nop), id_pc/id_pc4 preserved from previous contents.

Reset
REQ-030 rst SHALL immediately, without clock, set pc=RESET_PC, id_pc=0, id_pc4=0, id_inst=0, id_valid=0, id_fault=0, misalign=0.
REQ-031 rst asserted mid-stall or mid-redirect SHALL discard the pending operation; first rising edge after release SHALL perform a normal advance from RESET_PC.

Verification
REQ-032 Reset release, ROM word0=32'h2001_0005, word1=32'h2002_0007, no stall -> edge1: id_pc=0, id_inst=32'h2001_0005, id_valid=1, pc=4; edge2: id_pc=4, id_pc4=8, id_inst=32'h2002_0007.
REQ-033 stall=1 for 3 cycles at pc=8 -> pc stays 8, IF/ID unchanged 3 edges; after release next edge captures word2, pc=12.
REQ-034 br_taken=1, br_target=32'h0000_0040, stall=1 same cycle -> pc=32'h40, id_valid=0, id_inst=0; next edge id_pc=32'h40.
REQ-035 br_target=32'h0000_0022 -> pc=32'h20, misalign=1, stays 1 across 10 further cycles until rst.
REQ-036 pc reaches 32'h100 (IMEM_AW=6) -> captured id_fault=1, id_valid=0, id_inst=0; pc continues to 32'h104.
REQ-037 rst pulse asynchronously mid-cycle while pc=32'h1C, stall=1 -> outputs reach REQ-030 values before next edge; first edge after release captures word0.
